// File: rtl/mips_dcache.sv
`default_nettype none
// ============================================================================
// Module   : mips_dcache
// Brief    : Direct-mapped, write-through data cache with stall handshake and
//            saturating hit/miss/write statistics.
// Revision : 1.0 - initial release
// ============================================================================
module mips_dcache #(
    parameter int LINES       = 64,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [31:0]          address_input,
    input  logic [31:0]          read_data2,
    output logic [31:0]          read_data,
    output logic                 stall,
    output logic [31:0]          mem_addr,
    output logic [0:3][7:0]      mem_data_in,
    input  logic [0:3][7:0]      mem_data_out,
    output logic                 mem_write_en,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count,
    output logic [CNT_W-1:0]     write_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [LAT_W-1:0] C_LAST = LAT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MISS  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t             r_state, w_next_state;
    logic [LAT_W-1:0]   r_cnt, w_cnt_next;

    logic               r_valid [LINES];
    logic [TAG_W-1:0]   r_tag   [LINES];
    logic [31:0]        r_data  [LINES];

    logic [CNT_W-1:0]   r_hit_count, r_miss_count, r_write_count;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit, w_last;
    logic               w_hit_inc, w_miss_inc, w_write_inc;
    logic               w_fill, w_update;
    logic               w_unused;

    assign w_idx    = address_input[2 +: IDX_W];
    assign w_tag    = address_input[31 -: TAG_W];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last   = (r_cnt == C_LAST);
    assign w_unused = ^address_input[1:0];

    assign mem_addr    = {address_input[31:2], 2'b00};
    assign mem_data_in = read_data2;

    assign hit_count   = r_hit_count;
    assign miss_count  = r_miss_count;
    assign write_count = r_write_count;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        stall        = 1'b0;
        read_data    = 32'h0;
        mem_write_en = 1'b0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_write_inc  = 1'b0;
        w_fill       = 1'b0;
        w_update     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        stall        = 1'b1;
                        w_write_inc  = 1'b1;
                        w_next_state = S_WRITE;
                        w_cnt_next   = '0;
                    end else if (w_hit) begin
                        read_data    = r_data[w_idx];
                        w_hit_inc    = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        w_miss_inc   = 1'b1;
                        w_next_state = S_MISS;
                        w_cnt_next   = '0;
                    end
                end
            end
            S_MISS: begin
                if (w_last) begin
                    // Memory data is bypassed to the core in the fill cycle
                    read_data    = mem_data_out;
                    w_fill       = 1'b1;
                    w_next_state = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    stall        = 1'b1;
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            S_WRITE: begin
                mem_write_en = 1'b1;
                if (w_last) begin
                    w_update     = w_hit;
                    w_next_state = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    stall        = 1'b1;
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_hit_count   <= '0;
            r_miss_count  <= '0;
            r_write_count <= '0;
            for (int i = 0; i < LINES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
            end
            if (w_hit_inc && (r_hit_count != {CNT_W{1'b1}})) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_miss_inc && (r_miss_count != {CNT_W{1'b1}})) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
            if (w_write_inc && (r_write_count != {CNT_W{1'b1}})) begin
                r_write_count <= r_write_count + 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset; the valid bits qualify it
    always_ff @(posedge clk) begin
        if (!reset && w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_data_out;
        end else if (!reset && w_update) begin
            r_data[w_idx] <= read_data2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_dcache.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_dcache
// Brief    : Scoreboard bench for mips_dcache (main instance plus a
//            MEM_LATENCY=1 / CNT_W=2 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_dcache;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_write;
    logic [31:0]       address_input, read_data2, read_data, mem_addr;
    logic              stall, mem_write_en;
    logic [0:3][7:0]   mem_data_in, mem_data_out;
    logic [31:0]       hit_count, miss_count, write_count;

    logic              b_reset, b_req_valid, b_req_write;
    logic [31:0]       b_address_input, b_read_data2, b_read_data, b_mem_addr;
    logic              b_stall, b_mem_write_en;
    logic [0:3][7:0]   b_mem_data_in, b_mem_data_out;
    logic [1:0]        b_hit_count, b_miss_count, b_write_count;

    always #5 clk = ~clk;

    mips_dcache #(.LINES(64), .MEM_LATENCY(4), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .address_input(address_input), .read_data2(read_data2),
        .read_data(read_data), .stall(stall), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_write_en(mem_write_en), .hit_count(hit_count),
        .miss_count(miss_count), .write_count(write_count)
    );

    mips_dcache #(.LINES(4), .MEM_LATENCY(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_write(b_req_write),
        .address_input(b_address_input), .read_data2(b_read_data2),
        .read_data(b_read_data), .stall(b_stall), .mem_addr(b_mem_addr),
        .mem_data_in(b_mem_data_in), .mem_data_out(b_mem_data_out),
        .mem_write_en(b_mem_write_en), .hit_count(b_hit_count),
        .miss_count(b_miss_count), .write_count(b_write_count)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [7:0]  stalls;
        logic [7:0]  wes;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mon_stalls = 0;
    int   mon_wes    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a request completes on any cycle with req_valid high and stall low
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            mon_stalls = 0;
            mon_wes    = 0;
        end else if (req_valid) begin
            if (mem_write_en) mon_wes++;
            if (stall) begin
                mon_stalls++;
            end else begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got completion with read_data 0x%08h, expected none", read_data);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_read_data", read_data, e.rdata);
                    check("sb_stall_cycles", 32'(mon_stalls), 32'(e.stalls));
                    check("sb_we_cycles", 32'(mon_wes), 32'(e.wes));
                end
                mon_stalls = 0;
                mon_wes    = 0;
            end
        end
    end

    // Issue one request and hold it until the DUT lets the core advance
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] memword, input logic [31:0] exp_rd,
                          input int exp_stalls, input int exp_wes);
        exp_t e;
        int   budget;
        e.rdata  = exp_rd;
        e.stalls = 8'(exp_stalls);
        e.wes    = 8'(exp_wes);
        sb_q.push_back(e);
        req_valid     = 1'b1;
        req_write     = wr;
        address_input = addr;
        read_data2    = wdata;
        mem_data_out  = memword;
        budget        = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            budget++;
            if (budget > 20) begin
                n_tests++;
                n_fail++;
                $display("FAIL req_timeout: got stall held %0d cycles, expected at most 20", budget);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic check_cnt(input string name, input logic [31:0] h,
                             input logic [31:0] m, input logic [31:0] w);
        check({name, "_hit"}, hit_count, h);
        check({name, "_miss"}, miss_count, m);
        check({name, "_write"}, write_count, w);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        address_input = 32'h0; read_data2 = 32'h0; mem_data_out = 32'h0;
        b_reset = 1'b1; b_req_valid = 1'b0; b_req_write = 1'b0;
        b_address_input = 32'h0; b_read_data2 = 32'h0; b_mem_data_out = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        b_reset = 1'b0;

        @(negedge clk);
        check("rst_stall", 32'(stall), 0);
        check("rst_read_data", read_data, 0);
        check("rst_mem_we", 32'(mem_write_en), 0);
        check_cnt("rst", 0, 0, 0);
        @(posedge clk);
        #1;

        do_req(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 4, 0);
        check_cnt("miss1", 0, 1, 0);
        do_req(1'b0, 32'h100, 32'h0, 32'hFFFFFFFF, 32'hDEADBEEF, 0, 0);
        check_cnt("hit1", 1, 1, 0);

        // Store with nonzero low address bits to the resident word
        req_valid = 1'b1; req_write = 1'b1;
        address_input = 32'h102; read_data2 = 32'h12345678;
        #1;
        check("mem_addr", mem_addr, 32'h100);
        check("lane0", 32'(mem_data_in[0]), 32'h12);
        check("lane3", 32'(mem_data_in[3]), 32'h78);
        do_req(1'b1, 32'h102, 32'h12345678, 32'h0, 32'h0, 4, 4);
        check_cnt("store_hit", 1, 1, 1);
        do_req(1'b0, 32'h100, 32'h0, 32'hFFFFFFFF, 32'h12345678, 0, 0);
        check_cnt("hit2", 2, 1, 1);

        // 0x200 shares index 0 with 0x100: store miss must not allocate
        do_req(1'b1, 32'h200, 32'hCAFEF00D, 32'h0, 32'h0, 4, 4);
        do_req(1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 4, 0);
        check_cnt("no_alloc", 2, 2, 2);
        do_req(1'b0, 32'h100, 32'h0, 32'h12345678, 32'h12345678, 4, 0);
        do_req(1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 4, 0);
        check_cnt("conflict", 2, 4, 2);

        do_req(1'b0, 32'h104, 32'h0, 32'h0BADF00D, 32'h0BADF00D, 4, 0);
        do_req(1'b0, 32'h104, 32'h0, 32'hFFFFFFFF, 32'h0BADF00D, 0, 0);
        check_cnt("pre_rst", 3, 5, 2);

        // Reset in the second cycle of a miss
        req_valid = 1'b1; req_write = 1'b0; address_input = 32'h100;
        mem_data_out = 32'h55555555;
        @(posedge clk);
        #1;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_stall", 32'(stall), 0);
        check("mid_rst_read_data", read_data, 0);
        check("mid_rst_mem_we", 32'(mem_write_en), 0);
        check_cnt("mid_rst", 0, 0, 0);
        @(posedge clk);
        #1;
        check("mid_rst_idle_stall", 32'(stall), 0);
        do_req(1'b0, 32'h104, 32'h0, 32'h0BADF00D, 32'h0BADF00D, 4, 0);
        check_cnt("post_rst", 0, 1, 0);

        // MEM_LATENCY=1, CNT_W=2 instance
        b_req_valid = 1'b1; b_req_write = 1'b0;
        b_address_input = 32'h10; b_mem_data_out = 32'hA5A5A5A5;
        @(negedge clk);
        check("b_miss_stall", 32'(b_stall), 1);
        @(posedge clk);
        #1;
        b_mem_data_out = 32'h0;
        b_mem_data_out = 32'hA5A5A5A5;
        @(negedge clk);
        check("b_fill_stall", 32'(b_stall), 0);
        check("b_fill_data", b_read_data, 32'hA5A5A5A5);
        @(posedge clk);
        #1;
        b_mem_data_out = 32'h0;
        check("b_miss_count", 32'(b_miss_count), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("b_hit_stall", 32'(b_stall), 0);
            check("b_hit_data", b_read_data, 32'hA5A5A5A5);
            @(posedge clk);
            #1;
            if (k == 1) check("b_hit_count_2", 32'(b_hit_count), 2);
        end
        b_req_valid = 1'b0;
        check("b_hit_sat", 32'(b_hit_count), 3);

        check("sb_empty", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
